// File: rtl/mem_port_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter_pkg: shared encodings for the memory port arbiter | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mem_port_arbiter_pkg;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_C    = 2'b01;
  localparam logic [1:0] OWN_D    = 2'b10;

  // Bit positions of the two requesters in req/grant vectors
  localparam int PORT_C = 0;
  localparam int PORT_D = 1;

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2: combinational two-input round-robin grant (one-hot) | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // last = 1 means D won the previous grant, so a tie goes to C
  always_comb begin
    grant = req;
    if (&req) begin
      grant = 2'b00;
      grant[last ? PORT_C : PORT_D] = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter: shares one synchronous memory port between core and DMA | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        owner,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  generate
    if (LATENCY < 1 || LATENCY > (1 << CNT_W) - 1) begin : g_latency_check
      $error("mem_port_arbiter: LATENCY must be in 1..7");
    end
  endgenerate

  arb_state_e        state_q, state_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        owner_q, owner_d;
  logic              c_ack_q, c_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        grant;

  rr_arb2 u_rr_arb2 (
    .req   ({d_req, c_req}),
    .last  (last_q),
    .grant (grant)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    c_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          owner_d     = grant[PORT_D] ? OWN_D : OWN_C;
          last_d      = grant[PORT_D];
          mem_en_d    = 1'b1;
          mem_we_d    = grant[PORT_D] ? d_we    : c_we;
          mem_addr_d  = grant[PORT_D] ? d_addr  : c_addr;
          mem_wdata_d = grant[PORT_D] ? d_wdata : c_wdata;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mem_we_q) begin
          c_ack_d = (owner_q == OWN_C);
          d_ack_d = (owner_q == OWN_D);
          state_d = ST_DONE;
        end else begin
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Counter at zero marks the cycle in which mem_rdata is valid
        if (cnt_q == '0) begin
          rdata_d = mem_rdata;
          c_ack_d = (owner_q == OWN_C);
          d_ack_d = (owner_q == OWN_D);
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        owner_d = OWN_NONE;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      owner_q     <= OWN_NONE;
      c_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      c_ack_q     <= c_ack_d;
      d_ack_q     <= d_ack_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign c_ack     = c_ack_q;
  assign d_ack     = d_ack_q;
  assign rdata     = rdata_q;
  assign owner     = owner_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter: scoreboard bench over four LATENCY variants | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;

  logic [3:0]  c_ack_a, d_ack_a, mem_en_a, mem_we_a;
  logic [1:0]  owner_a     [4];
  logic [31:0] rdata_a     [4];
  logic [31:0] mem_addr_a  [4];
  logic [31:0] mem_wdata_a [4];
  logic [31:0] mem_rdata_a [4];

  typedef struct {
    bit          port_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          t_req;   // -1: sampled in the IDLE cycle after the previous ack
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          sel = 0;
  bit          mon_on = 0;
  int          issue_cyc = 0;
  int          last_ack = 0;
  logic [31:0] model_rdata = '0;
  int          n_chk = 0;
  int          n_err = 0;

  function automatic int lat_of(input int s);
    return (s == 0) ? 1 : (s == 1) ? 2 : (s == 2) ? 4 : 7;
  endfunction

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : ((a * 32'h9E3779B1) ^ 32'h5A5A0000);
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  generate
    for (genvar i = 0; i < 4; i++) begin : g_dut
      localparam int L = (i == 0) ? 1 : (i == 1) ? 2 : (i == 2) ? 4 : 7;
      logic [7:0]  pv = '0;
      logic [31:0] pd [8];
      logic [31:0] garb = '0;

      mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(L)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .c_req     (c_req),
        .c_we      (c_we),
        .c_addr    (c_addr),
        .c_wdata   (c_wdata),
        .c_ack     (c_ack_a[i]),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack_a[i]),
        .rdata     (rdata_a[i]),
        .owner     (owner_a[i]),
        .mem_en    (mem_en_a[i]),
        .mem_we    (mem_we_a[i]),
        .mem_addr  (mem_addr_a[i]),
        .mem_wdata (mem_wdata_a[i]),
        .mem_rdata (mem_rdata_a[i])
      );

      // Memory: read data valid exactly L cycles after the strobe, noise otherwise
      always @(posedge clk) begin
        pv    <= {pv[6:0], mem_en_a[i] & ~mem_we_a[i]};
        pd[0] <= mdata(mem_addr_a[i]);
        for (int k = 1; k < 8; k++) pd[k] <= pd[k-1];
        garb  <= $urandom;
      end
      assign mem_rdata_a[i] = pv[L-1] ? pd[L-1] : garb;
    end
  endgenerate

  always @(negedge clk) begin
    if (mon_on) begin
      if (rst) begin
        model_rdata = '0;
      end else begin
        check("both_ack", c_ack_a[sel] & d_ack_a[sel], 0);
        if (mem_en_a[sel]) begin
          if (sb.size() == 0) begin
            check("spurious_en", 1, 0);
          end else begin
            mon_e = sb[0];
            check("issue_cyc", cyc, ((mon_e.t_req < 0) ? last_ack + 1 : mon_e.t_req) + 1);
            check("owner", owner_a[sel], mon_e.port_d ? 2'b10 : 2'b01);
            check("mem_addr", mem_addr_a[sel], mon_e.addr);
            check("mem_we", mem_we_a[sel], mon_e.we);
            if (mon_e.we) check("mem_wdata", mem_wdata_a[sel], mon_e.wdata);
            issue_cyc = cyc;
          end
        end
        if (c_ack_a[sel] | d_ack_a[sel]) begin
          if (sb.size() == 0) begin
            check("spurious_ack", 1, 0);
          end else begin
            mon_e = sb.pop_front();
            check("ack_port", d_ack_a[sel], mon_e.port_d);
            check("ack_lat", cyc - issue_cyc, mon_e.we ? 1 : 1 + lat_of(sel));
            check("owner_ack", owner_a[sel], mon_e.port_d ? 2'b10 : 2'b01);
            if (!mon_e.we) model_rdata = mdata(mon_e.addr);
            check("rdata", rdata_a[sel], model_rdata);
            last_ack = cyc;
          end
        end
      end
    end
  end

  task automatic push(input bit pd, input bit we, input logic [31:0] a,
                      input logic [31:0] w, input int t);
    exp_t e;
    e.port_d = pd; e.we = we; e.addr = a; e.wdata = w; e.t_req = t;
    sb.push_back(e);
  endtask

  task automatic run_until(input int n);
    int k;
    for (k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      if (sb.size() <= n) break;
    end
    if (k == 80) begin
      check("timeout", sb.size(), n);
      sb.delete();
    end
  endtask

  task automatic txn(input bit pd, input bit we, input logic [31:0] a, input logic [31:0] w);
    @(posedge clk); #1;
    push(pd, we, a, w, cyc);
    if (pd) begin d_req = 1; d_we = we; d_addr = a; d_wdata = w; end
    else    begin c_req = 1; c_we = we; c_addr = a; c_wdata = w; end
    run_until(0);
    c_req = 0; d_req = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; c_req = 0; d_req = 0; c_we = 0; d_we = 0;
    sb.delete();
    @(posedge clk); #1;
    rst = 0;
  endtask

  initial begin
    rst = 1; c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    check("rst_owner", owner_a[1], 0);
    check("rst_c_ack", c_ack_a[1], 0);
    check("rst_d_ack", d_ack_a[1], 0);
    check("rst_mem_en", mem_en_a[1], 0);
    check("rst_mem_we", mem_we_a[1], 0);
    check("rst_mem_addr", mem_addr_a[1], 0);
    check("rst_mem_wdata", mem_wdata_a[1], 0);
    check("rst_rdata", rdata_a[1], 0);
    mon_on = 1;

    sel = 1;
    txn(0, 0, 32'h100, 32'h0);

    do_reset(); sel = 0;
    txn(0, 0, 32'h200, 32'h0);
    txn(1, 1, 32'h40, 32'h12345678);

    // Contention: both held, expect C D C D starting with C after reset
    do_reset(); sel = 0;
    @(posedge clk); #1;
    push(0, 0, 32'h300, 32'h0, cyc);
    push(1, 1, 32'h380, 32'hCAFEF00D, -1);
    push(0, 0, 32'h300, 32'h0, -1);
    push(1, 1, 32'h380, 32'hCAFEF00D, -1);
    c_req = 1; c_we = 0; c_addr = 32'h300;
    d_req = 1; d_we = 1; d_addr = 32'h380; d_wdata = 32'hCAFEF00D;
    run_until(0);
    c_req = 0; d_req = 0;

    // Held request: address changes in the IDLE cycle after the first ack
    do_reset(); sel = 1;
    @(posedge clk); #1;
    push(0, 0, 32'h104, 32'h0, cyc);
    push(0, 0, 32'h108, 32'h0, -1);
    c_req = 1; c_we = 0; c_addr = 32'h104;
    run_until(1);
    c_addr = 32'h108;
    run_until(0);
    c_req = 0;

    // Reset in the middle of a LATENCY=4 read
    do_reset(); sel = 2;
    @(posedge clk); #1;
    push(0, 0, 32'h400, 32'h0, cyc);
    c_req = 1; c_we = 0; c_addr = 32'h400;
    repeat (3) @(posedge clk);
    #3 rst = 1; c_req = 0;
    sb.delete();
    #1;
    check("mid_rst_owner", owner_a[2], 0);
    check("mid_rst_mem_en", mem_en_a[2], 0);
    check("mid_rst_c_ack", c_ack_a[2], 0);
    check("mid_rst_mem_addr", mem_addr_a[2], 0);
    check("mid_rst_rdata", rdata_a[2], 0);
    @(posedge clk); #1 rst = 0;
    repeat (8) begin
      @(negedge clk);
      check("no_ack_after_rst", c_ack_a[2] | d_ack_a[2], 0);
    end
    txn(1, 0, 32'h44, 32'h0);

    do_reset(); sel = 3;
    txn(0, 0, 32'h700, 32'h0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
